pipe_buffer: RTL

//  Parametrised elastic pipeline register between two Venus pipeline stages (IF/ID, ID/EX, EX/WB).
//  - Both sides use the core valid/stall handshake.
//  - Holds up to DEPTH words of stage payload.
//  - Adds a synchronous flush for branch redirect.
//  - stall_o is driven from state only, so there is no combinational stall path upstream.

---
 rtl/pipe_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipe_buffer.sv
// Elastic pipeline register between two pipeline stages. It holds up to DEPTH
// words and uses a valid/stall handshake on both sides. A synchronous flush
// empties it. Every output comes from a flop, so stall_o has no combinational
// path from stall_i.
module pipe_buffer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         v_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic                         stall_o,
    output logic                         v_o,
    output logic [WIDTH-1:0]             data_o,
    input  logic                         stall_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    // Storage is padded to a power of two so the pointer width matches the
    // index width exactly. Pointers still wrap at DEPTH-1.
    localparam int unsigned SLOTS = 1 << PW;

    logic [WIDTH-1:0] mem_q [SLOTS];
    logic [WIDTH-1:0] mem_d [SLOTS];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             v_q, v_d;
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             push, pop;

    // Advance a pointer by one, returning to 0 after DEPTH-1.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Handshake, storage write, pointer/count update and next-cycle output decode.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        push = v_i & ~stall_q & ~flush_i;
        pop  = v_q & ~stall_i & ~flush_i;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end

        v_d     = (count_d != '0);
        stall_d = (count_d == CW'(DEPTH));
        data_d  = mem_d[rd_ptr_d];
    end

    // State and output registers with an asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            v_q      <= 1'b0;
            stall_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            v_q      <= v_d;
            stall_q  <= stall_d;
            data_q   <= data_d;
        end
    end

    assign stall_o = stall_q;
    assign v_o     = v_q;
    assign data_o  = data_q;
    assign count_o = count_q;

endmodule
